// File: rtl/array_reduce_pkg.sv
// Shared types and identity values for the array reduction kernel.
// Latency: n/a. Backpressure: n/a.
package array_reduce_pkg;

    typedef enum logic [1:0] {
        OP_SUM = 2'd0,
        OP_MAX = 2'd1,
        OP_MIN = 2'd2,
        OP_XOR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Identities are all-zeros or all-ones, so store the fill bit and replicate.
    localparam logic ID_FILL_SUM = 1'b0;
    localparam logic ID_FILL_MAX = 1'b0;
    localparam logic ID_FILL_MIN = 1'b1;
    localparam logic ID_FILL_XOR = 1'b0;

    function automatic logic id_fill(input op_t op);
        case (op)
            OP_SUM:  return ID_FILL_SUM;
            OP_MAX:  return ID_FILL_MAX;
            OP_MIN:  return ID_FILL_MIN;
            default: return ID_FILL_XOR;
        endcase
    endfunction

endpackage

// File: rtl/array_reduce_kernel_if.sv
// Memory-side bus of the reduction kernel: memory clock, read port, write port.
// Latency: read data returns a fixed number of cycles after the request. Backpressure: none.
interface array_reduce_kernel_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              arr_clk;
    logic              arr_read_en;
    logic [ADDR_W-1:0] arr_read_addr_arg;
    logic [DATA_W-1:0] arr_read_val_ret;
    logic              arr_write_en;
    logic [ADDR_W-1:0] arr_write_addr_arg;
    logic [DATA_W-1:0] arr_write_val_arg;

    modport master (
        output arr_clk, arr_read_en, arr_read_addr_arg,
        input  arr_read_val_ret,
        output arr_write_en, arr_write_addr_arg, arr_write_val_arg
    );

    modport slave (
        input  arr_clk, arr_read_en, arr_read_addr_arg,
        output arr_read_val_ret,
        input  arr_write_en, arr_write_addr_arg, arr_write_val_arg
    );
endinterface

// File: rtl/array_reduce_alu.sv
// Combine step of the reduction: folds one element into the accumulator.
// Latency: combinational. Backpressure: none.
module array_reduce_alu
    import array_reduce_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] elem,
    output logic [DATA_W-1:0] nxt
);
    always_comb begin
        nxt = acc;
        unique case (op)
            OP_SUM: nxt = acc + elem;
            OP_MAX: nxt = (elem > acc) ? elem : acc;
            OP_MIN: nxt = (elem < acc) ? elem : acc;
            OP_XOR: nxt = acc ^ elem;
        endcase
    end
endmodule

// File: rtl/array_reduce_kernel.sv
// Reduces n memory elements (SUM/MAX/MIN/XOR); ARRAY_REDUCE_PREFIX_WB_EN adds SUM prefix write-back.
// Latency: finish n+RD_LAT+1 cycles after start (+1 with write-back on SUM). Backpressure: none, start ignored while busy.
module array_reduce_kernel
    import array_reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  finish,
    input  logic [ADDR_W-1:0]     n,
    input  logic [1:0]            op,
    output logic [DATA_W-1:0]     res,
    array_reduce_kernel_if.master mem
);
    localparam logic [RD_LAT-1:0] VLD_TAIL = RD_LAT'(1) << (RD_LAT - 1);

    state_t            state;
    op_t               op_in;
    op_t               op_q;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [RD_LAT-1:0] vld;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] alu_out;
    logic              consume;
    logic              wb_on;
    logic              drain_done;

    assign op_in   = op_t'(op);
    assign consume = vld[RD_LAT-1];

    array_reduce_alu #(.DATA_W(DATA_W)) u_alu (
        .op   (op_q),
        .acc  (acc),
        .elem (mem.arr_read_val_ret),
        .nxt  (alu_out)
    );

    assign acc_next = consume ? alu_out : acc;

    // With write-back the last prefix write needs one more cycle after the final consume.
    assign drain_done = wb_on ? (vld == '0) : ((vld & ~VLD_TAIL) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_SUM;
            n_q     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b0;
            vld     <= '0;
            acc     <= '0;
            res     <= '0;
            finish  <= 1'b0;
        end else begin
            finish <= 1'b0;
            vld    <= (vld << 1) | RD_LAT'(rd_en);
            acc    <= acc_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op_in;
                        n_q     <= n;
                        rd_addr <= '0;
                        acc     <= {DATA_W{id_fill(op_in)}};
                        if (n != '0) begin
                            state <= ST_RUN;
                            rd_en <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            finish <= 1'b1;
                            res    <= {DATA_W{id_fill(op_in)}};
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_addr == n_q - ADDR_W'(1)) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state  <= ST_DONE;
                        finish <= 1'b1;
                        res    <= acc_next;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem.arr_clk           = clk;
    assign mem.arr_read_en       = rd_en;
    assign mem.arr_read_addr_arg = rd_addr;

`ifdef ARRAY_REDUCE_PREFIX_WB_EN
    logic [ADDR_W-1:0] cons_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_val;
    logic              wr_now;

    assign wb_on  = (op_q == OP_SUM);
    assign wr_now = consume && wb_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cons_idx <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_val   <= '0;
        end else begin
            wr_en   <= wr_now;
            wr_addr <= wr_now ? cons_idx : '0;
            wr_val  <= wr_now ? acc_next : '0;
            if (state == ST_IDLE) begin
                cons_idx <= '0;
            end else if (consume) begin
                cons_idx <= cons_idx + ADDR_W'(1);
            end
        end
    end

    assign mem.arr_write_en       = wr_en;
    assign mem.arr_write_addr_arg = wr_addr;
    assign mem.arr_write_val_arg  = wr_val;
`else
    assign wb_on                  = 1'b0;
    assign mem.arr_write_en       = 1'b0;
    assign mem.arr_write_addr_arg = '0;
    assign mem.arr_write_val_arg  = '0;
`endif
endmodule

// File: tb/tb_array_reduce_kernel.sv
// Directed bench for array_reduce_kernel: two instances (read latency 1 and 3) share stimulus,
// each with its own memory model; expectations are hand-computed per step.
module tb_array_reduce_kernel;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  n = '0;
    logic [1:0]  op = '0;
    logic        fin1, fin3;
    logic [31:0] res1, res3;

    array_reduce_kernel_if #(.DATA_W(32), .ADDR_W(10)) m1 ();
    array_reduce_kernel_if #(.DATA_W(32), .ADDR_W(10)) m3 ();

    array_reduce_kernel #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(fin1),
        .n(n), .op(op), .res(res1), .mem(m1)
    );
    array_reduce_kernel #(.DATA_W(32), .ADDR_W(10), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(fin3),
        .n(n), .op(op), .res(res3), .mem(m3)
    );

    always #5 clk = ~clk;

    // Memory models: latency 1 and latency 3 registered reads, synchronous writes.
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] q1, q3a, q3b, q3c;
    always @(posedge clk) begin
        if (m1.arr_write_en) mem1[m1.arr_write_addr_arg[3:0]] <= m1.arr_write_val_arg;
        if (m3.arr_write_en) mem3[m3.arr_write_addr_arg[3:0]] <= m3.arr_write_val_arg;
        q1  <= mem1[m1.arr_read_addr_arg[3:0]];
        q3a <= mem3[m3.arr_read_addr_arg[3:0]];
        q3b <= q3a;
        q3c <= q3b;
    end
    assign m1.arr_read_val_ret = q1;
    assign m3.arr_read_val_ret = q3c;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t0, cur_n, mk;
    int rd1, rd3, bad1, bad3, f1, f3, f1c, f3c, nw, wtot;
`ifdef ARRAY_REDUCE_PREFIX_WB_EN
    int          wcyc  [8];
    logic [31:0] waddr [8];
    logic [31:0] wval  [8];
`endif

    always @(negedge clk) begin
        mk = cyc - t0;
        if (m1.arr_read_en) begin
            rd1++;
            if (m1.arr_read_addr_arg != 10'(mk - 1) || mk < 1 || mk > cur_n) bad1++;
        end
        if (m3.arr_read_en) begin
            rd3++;
            if (m3.arr_read_addr_arg != 10'(mk - 1) || mk < 1 || mk > cur_n) bad3++;
        end
        if (fin1) begin f1++; if (f1c < 0) f1c = mk; end
        if (fin3) begin f3++; if (f3c < 0) f3c = mk; end
        if (m1.arr_write_en) begin
`ifdef ARRAY_REDUCE_PREFIX_WB_EN
            if (nw < 8) begin
                wcyc[nw]  = mk;
                waddr[nw] = 32'(m1.arr_write_addr_arg);
                wval[nw]  = m1.arr_write_val_arg;
            end
`endif
            nw++;
            wtot++;
        end
        if (m3.arr_write_en) wtot++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd1 = 0; rd3 = 0; bad1 = 0; bad3 = 0;
        f1 = 0; f3 = 0; f1c = -1; f3c = -1; nw = 0;
    endtask

    task automatic load(input logic [31:0] a0, a1, a2, a3);
        mem1[0] = a0; mem1[1] = a1; mem1[2] = a2; mem1[3] = a3;
        mem3[0] = a0; mem3[1] = a1; mem3[2] = a2; mem3[3] = a3;
    endtask

    task automatic run(input logic [1:0] o, input int len, input int win);
        @(negedge clk);
        clear_mon();
        t0 = cyc; cur_n = len;
        op = o; n = 10'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (win) @(negedge clk);
        #1;
    endtask

    function automatic int efin(input int lat, input logic [1:0] o, input int len);
        int r;
        if (len == 0) return 1;
        r = len + lat + 1;
`ifdef ARRAY_REDUCE_PREFIX_WB_EN
        if (o == 2'd0) r++;
`endif
        return r;
    endfunction

    task automatic verify(input string tag, input logic [31:0] er, input logic [1:0] o, input int len);
        chk({tag, ".res1"},  res1, er);
        chk({tag, ".res3"},  res3, er);
        chk({tag, ".fcyc1"}, f1c, efin(1, o, len));
        chk({tag, ".fcyc3"}, f3c, efin(3, o, len));
        chk({tag, ".fcnt1"}, f1, 1);
        chk({tag, ".fcnt3"}, f3, 1);
        chk({tag, ".rd1"},   rd1, len);
        chk({tag, ".rd3"},   rd3, len);
        chk({tag, ".bad1"},  bad1, 0);
        chk({tag, ".bad3"},  bad3, 0);
    endtask

    initial begin
        logic [31:0] pref [4];
        pref[0] = 1; pref[1] = 3; pref[2] = 6; pref[3] = 10;
        clear_mon();
        t0 = 0; cur_n = 0; wtot = 0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst.fin1", fin1, 0);
        chk("rst.rden1", m1.arr_read_en, 0);
        chk("rst.wren1", m1.arr_write_en, 0);
        chk("rst.res1", res1, 0);
        chk("rst.rden3", m3.arr_read_en, 0);
        chk("rst.res3", res3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("arr_clk", m1.arr_clk, clk);

        // SUM [1,2,3,4]
        load(1, 2, 3, 4);
        run(2'd0, 4, 14);
        verify("sum4", 10, 2'd0, 4);
`ifdef ARRAY_REDUCE_PREFIX_WB_EN
        chk("wb.count", nw, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wb.addr%0d", i), waddr[i], i);
            chk($sformatf("wb.val%0d", i), wval[i], pref[i]);
            chk($sformatf("wb.cyc%0d", i), wcyc[i], 3 + i);
        end
        chk("wb.fin_after_last", f1c, wcyc[3] + 1);
`else
        chk("sum4.nowrite", nw, 0);
`endif

        // MAX then MIN, unsigned compare
        load(5, 32'hFFFF_FFF0, 7, 0);
        run(2'd1, 3, 14);
        verify("max", 32'hFFFF_FFF0, 2'd1, 3);
        run(2'd2, 3, 14);
        verify("min", 5, 2'd2, 3);

        // Reset in the middle of a run, then a fresh XOR run
        load(9, 9, 9, 9);
        @(negedge clk);
        clear_mon();
        t0 = cyc; cur_n = 4;
        op = 2'd3; n = 10'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.fin1", fin1, 0);
        chk("abort.rden1", m1.arr_read_en, 0);
        chk("abort.rden3", m3.arr_read_en, 0);
        chk("abort.res1", res1, 0);
        chk("abort.res3", res3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        chk("abort.nofin1", f1, 0);
        chk("abort.nofin3", f3, 0);
        load(3, 5, 0, 0);
        run(2'd3, 2, 14);
        verify("xor", 6, 2'd3, 2);

        // SUM wraps modulo 2^32
        load(32'hFFFF_FFFF, 2, 0, 0);
        run(2'd0, 2, 14);
        verify("wrap", 1, 2'd0, 2);

        // Empty array
        run(2'd0, 0, 14);
        verify("n0", 0, 2'd0, 0);

        // start held high across runs: restarts only after IDLE is re-entered
        load(1, 2, 0, 0);
        @(negedge clk);
        clear_mon();
        t0 = cyc; cur_n = 2;
        op = 2'd3; n = 10'd2; start = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("hold.fcnt1", f1, 2);
        chk("hold.fcyc1", f1c, 4);
        chk("hold.rd1", rd1, 4);
        chk("hold.fcnt3", f3, 1);
        chk("hold.fcyc3", f3c, 6);
        chk("hold.rd3", rd3, 4);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("hold.res1", res1, 3);
        chk("hold.res3", res3, 3);
`ifndef ARRAY_REDUCE_PREFIX_WB_EN
        chk("nowrite.total", wtot, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
